flu_issue_scheduler: RTL
========================

# flu_issue_scheduler

Issue-side scheduler for the fixed-latency unit (FLU) group in the execute stage: ALU/branch, CSR buffer and multiplier/divider. It decides each cycle whether the instruction offered by issue may enter the FLU. It tracks the shared single writeback port with a reservation shift register, the single-entry CSR buffer, and the multi-cycle divider. It produces per-unit valid strobes and the FLU writeback valid/trans-id, so that no two results collide on the port.

## Interface
- TRANS_ID_BITS, 3, scoreboard transaction id width
- MUL_LAT, 1, multiplier result latency in cycles; legal 1..4
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- flush_i  in  1  pipeline flush; discards all in-flight FLU state
- issue_valid_i  in  1  issue offers an FLU instruction
- issue_fu_i  in  2  class: 0 ALU/branch, 1 CSR, 2 MUL, 3 DIV
- issue_trans_id_i  in  TRANS_ID_BITS  scoreboard id of offered instruction
- issue_ready_o  out  1  offered instruction is accepted this cycle
- csr_commit_i  in  1  buffered CSR instruction commits; frees CSR buffer
- div_done_i  in  1  divider result presented this cycle (single-cycle pulse)
- alu_valid_o  out  1  ALU/branch strobe
- csr_valid_o  out  1  CSR buffer strobe
- mult_valid_o  out  1  mult/div unit strobe (MUL or DIV)
- wb_valid_o  out  1  FLU writeback port carries a result
- wb_trans_id_o  out  TRANS_ID_BITS  id of result on writeback port
- wb_src_o  out  2  source of writeback, same encoding as issue_fu_i
- stall_cnt_o  out  16  saturating count of stalled issue cycles

## Operation
- State: res_q[MUL_LAT:1]; tid_q[MUL_LAT:1]; csr_full_q; div_busy_q; div_tid_q; stall_cnt_q.
- res_q[k]=1 means a MUL result occupies the port k cycles from now. The register shifts toward index 1 each cycle. Entry 1 is written back the next cycle.
- mul_wb = res_q[1] registered as the current-cycle MUL writeback, carried as a 1-bit stage res0_q with tid0_q.
- Acceptance rules (issue_ready_o, combinational):
  - Any class requires !flush_i and !csr_full_q.
  - ALU: !res0_q and !div_done_i.
  - CSR: same as ALU. The CSR result is written back at issue.
  - MUL: !div_busy_q and the slot landing at MUL_LAT is free.
  - DIV: !div_busy_q and res0_q, res_q all zero.
- Accepted ALU/CSR: alu_valid_o/csr_valid_o high. wb_valid_o is high the same cycle with issue_trans_id_i and wb_src_o=class.
- Accepted CSR sets csr_full_q at the edge. csr_commit_i clears it at the edge. Set and clear in the same cycle: set wins (new entry).
- Accepted MUL: mult_valid_o high. It sets the reservation and id at depth MUL_LAT. It writes back exactly MUL_LAT cycles later with wb_src_o=2.
- Accepted DIV: mult_valid_o high. It sets div_busy_q and stores div_tid_q. div_done_i drives wb_valid_o, wb_trans_id_o=div_tid_q, wb_src_o=3, and clears div_busy_q at the edge.
- The rules guarantee at most one writeback per cycle. The bench asserts this. div_done_i without div_busy_q is ignored.
- stall_cnt_q increments when issue_valid_i && !issue_ready_o. It saturates at 16'hFFFF and is not cleared by flush_i.
- flush_i clears res_q, res0_q, csr_full_q, div_busy_q at the edge. During the flush cycle issue_ready_o=0, and writebacks in that cycle are suppressed (wb_valid_o=0).

## Timing
- Reset: all state zero. issue_ready_o follows from rules (1 for any class when issue_valid_i). All strobes, wb_valid_o, wb_trans_id_o, wb_src_o, stall_cnt_o = 0.
- ALU/CSR: latency 0, writeback in the acceptance cycle.
- MUL: writeback at acceptance cycle + MUL_LAT.
- Back-to-back MUL: accepted every cycle, no bubbles.
- ALU after MUL: ALU is blocked in the cycle the MUL writes back.
- DIV: variable latency, ended by div_done_i. ALU/CSR are blocked in the div_done_i cycle. MUL/DIV are blocked until the cycle after div_done_i.
- CSR buffer: the first cycle a second CSR (or any FLU op) may be accepted is the cycle after csr_commit_i.
- Reset mid-operation: all pending results are dropped immediately. No writeback follows.

## Test plan
- Reset, then ALU id 5 offered -> issue_ready_o=1, alu_valid_o=1, wb_valid_o=1, wb_trans_id_o=5, wb_src_o=0 same cycle.
- MUL_LAT=1: MUL id 2 at cycle t, ALU id 3 at t+1 -> ALU stalled at t+1. wb id 2 src 2 at t+1. ALU accepted at t+2. stall_cnt_o=1.
- MUL ids 1,2,3 on consecutive cycles -> all accepted. Writebacks ids 1,2,3 on consecutive cycles MUL_LAT later.
- DIV id 4, then MUL offered for 10 cycles, div_done_i at 10th -> MUL stalled throughout. wb id 4 src 3. MUL accepted next cycle. stall_cnt_o=10.
- CSR id 6 accepted, then ALU offered -> blocked until cycle after csr_commit_i. Commit and new CSR in same cycle leave csr_full_q=1.
- MUL id 7 accepted, flush_i next cycle -> no writeback for id 7. csr_full_q/div_busy_q=0. Issue accepted the cycle after flush.

Source files
------------

// File: rtl/flu_issue_scheduler.sv
// Issue-side scheduler for the fixed-latency unit group (ALU/branch, CSR
// buffer, multiplier/divider). It arbitrates the single shared writeback
// port so that no two results ever land on it in the same cycle.
module flu_issue_scheduler #(
    parameter int TRANS_ID_BITS = 3,
    parameter int MUL_LAT       = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    input  logic [1:0]               issue_fu_i,
    input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
    output logic                     issue_ready_o,
    input  logic                     csr_commit_i,
    input  logic                     div_done_i,
    output logic                     alu_valid_o,
    output logic                     csr_valid_o,
    output logic                     mult_valid_o,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [1:0]               wb_src_o,
    output logic [15:0]              stall_cnt_o
);

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_CSR = 2'd1;
    localparam logic [1:0] FU_MUL = 2'd2;
    localparam logic [1:0] FU_DIV = 2'd3;

    // Multiplier reservation pipe. Bit 0 is the MUL result on the port in
    // the current cycle; bit k is a result landing k cycles from now. A MUL
    // accepted this cycle enters at depth MUL_LAT-1 after the edge so that it
    // reaches bit 0 exactly MUL_LAT cycles after acceptance.
    logic [MUL_LAT-1:0]       res_q, res_d;
    logic [TRANS_ID_BITS-1:0] tid_q [MUL_LAT];
    logic [TRANS_ID_BITS-1:0] tid_d [MUL_LAT];
    logic                     csr_full_q, csr_full_d;
    logic                     div_busy_q, div_busy_d;
    logic [TRANS_ID_BITS-1:0] div_tid_q, div_tid_d;
    logic [15:0]              stall_cnt_q, stall_cnt_d;

    logic div_wb, class_ok;
    logic acc_alu, acc_csr, acc_mul, acc_div;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A done pulse only counts while a divide is actually outstanding.
    assign div_wb = div_done_i && div_busy_q;

    // Per-class admission: ALU/CSR write back immediately, so they need the
    // port free now; MUL relies on fixed latency and only waits on the
    // divider; DIV needs the whole reservation pipe drained because its
    // completion time is unknown.
    always_comb begin
        class_ok = 1'b0;
        case (issue_fu_i)
            FU_ALU, FU_CSR: class_ok = !res_q[0] && !div_wb;
            FU_MUL:         class_ok = !div_busy_q;
            FU_DIV:         class_ok = !div_busy_q && (res_q == '0);
            default:        class_ok = 1'b0;
        endcase
    end

    assign issue_ready_o = issue_valid_i && !flush_i && !csr_full_q && class_ok;
    assign acc_alu       = issue_ready_o && (issue_fu_i == FU_ALU);
    assign acc_csr       = issue_ready_o && (issue_fu_i == FU_CSR);
    assign acc_mul       = issue_ready_o && (issue_fu_i == FU_MUL);
    assign acc_div       = issue_ready_o && (issue_fu_i == FU_DIV);

    assign alu_valid_o   = acc_alu;
    assign csr_valid_o   = acc_csr;
    assign mult_valid_o  = acc_mul || acc_div;
    assign stall_cnt_o   = stall_cnt_q;

    // Writeback port mux; admission rules keep these sources mutually exclusive.
    always_comb begin
        wb_valid_o    = 1'b0;
        wb_trans_id_o = '0;
        wb_src_o      = 2'd0;
        if (!flush_i) begin
            if (acc_alu || acc_csr) begin
                wb_valid_o    = 1'b1;
                wb_trans_id_o = issue_trans_id_i;
                wb_src_o      = issue_fu_i;
            end else if (res_q[0]) begin
                wb_valid_o    = 1'b1;
                wb_trans_id_o = tid_q[0];
                wb_src_o      = FU_MUL;
            end else if (div_wb) begin
                wb_valid_o    = 1'b1;
                wb_trans_id_o = div_tid_q;
                wb_src_o      = FU_DIV;
            end
        end
    end

    // Next state: shift reservations, track CSR buffer and divider, count stalls.
    always_comb begin
        res_d = '0;
        for (int k = 0; k < MUL_LAT; k++) tid_d[k] = tid_q[k];
        for (int k = 0; k < MUL_LAT - 1; k++) begin
            res_d[k] = res_q[k+1];
            tid_d[k] = tid_q[k+1];
        end
        if (acc_mul) begin
            res_d[MUL_LAT-1] = 1'b1;
            tid_d[MUL_LAT-1] = issue_trans_id_i;
        end

        csr_full_d = csr_full_q;
        if (acc_csr)           csr_full_d = 1'b1;
        else if (csr_commit_i) csr_full_d = 1'b0;

        div_busy_d = div_busy_q;
        div_tid_d  = div_tid_q;
        if (acc_div) begin
            div_busy_d = 1'b1;
            div_tid_d  = issue_trans_id_i;
        end else if (div_wb) begin
            div_busy_d = 1'b0;
        end

        if (flush_i) begin
            res_d      = '0;
            csr_full_d = 1'b0;
            div_busy_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (issue_valid_i && !issue_ready_o) stall_cnt_d = sat_inc(stall_cnt_q);
    end

    // State registers; reset drops every pending result at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_q       <= '0;
            for (int k = 0; k < MUL_LAT; k++) tid_q[k] <= '0;
            csr_full_q  <= 1'b0;
            div_busy_q  <= 1'b0;
            div_tid_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            res_q       <= res_d;
            for (int k = 0; k < MUL_LAT; k++) tid_q[k] <= tid_d[k];
            csr_full_q  <= csr_full_d;
            div_busy_q  <= div_busy_d;
            div_tid_q   <= div_tid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
